// File: rtl/sub_serial_nbit_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface sub_serial_nbit_if #(
    parameter int N = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   diff;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff
    );
endinterface

// File: rtl/sub_serial_nbit.sv
// Bit-serial N-bit subtractor (a - b, LSB first) with valid/ready on both sides.
// Optional SUB_ABS_EN: sign-magnitude result via an extra one-cycle NEGATE state.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready=1
// SHIFT  | one difference bit per cycle, N cycles
// NEGATE | conditional magnitude fix-up (SUB_ABS_EN only)
// DONE   | result held, out_valid=1
module sub_serial_nbit #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    sub_serial_nbit_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_res;
    logic         r_borrow;
    logic [CW-1:0] r_cnt;
    logic [N:0]   r_diff;
    logic         r_in_ready;
    logic         r_out_valid;

    logic         w_d;
    logic         w_borrow_nxt;
    logic         w_last;
    logic [N-1:0] w_res_nxt;

    assign w_d          = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    assign w_last       = (r_cnt == CW'(N - 1));

    always_comb begin
        w_res_nxt        = r_res >> 1;
        w_res_nxt[N-1]   = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (bus.in_valid) w_state_nxt = SHIFT;
`ifdef SUB_ABS_EN
            SHIFT:  if (w_last) w_state_nxt = NEGATE;
            NEGATE: w_state_nxt = DONE;
`else
            SHIFT:  if (w_last) w_state_nxt = DONE;
`endif
            DONE:   if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_borrow_nxt;
                    r_res    <= w_res_nxt;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) r_diff <= {w_borrow_nxt, w_res_nxt};
                end
`ifdef SUB_ABS_EN
                NEGATE: begin
                    if (r_diff[N]) r_diff[N-1:0] <= -r_diff[N-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
endmodule

// File: tb/tb_sub_serial_nbit.sv
// Scoreboard bench for sub_serial_nbit at N=10; follows SUB_ABS_EN if defined.
module tb_sub_serial_nbit;
    localparam int N = 10;
`ifdef SUB_ABS_EN
    localparam int LAT = N + 1;
    localparam logic [N:0] E_33_66 = 11'h421;
    localparam logic [N:0] E_0_1023 = 11'h7FF;
    localparam logic [N:0] E_7_9 = 11'h402;
`else
    localparam int LAT = N;
    localparam logic [N:0] E_33_66 = 11'h7DF;
    localparam logic [N:0] E_0_1023 = 11'h401;
    localparam logic [N:0] E_7_9 = 11'h7FE;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sub_serial_nbit_if #(.N(N)) bus ();
    sub_serial_nbit #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_edge = 0;
    int prev_acc = -1;
    bit b2b_mode = 0;
    bit ov_prev = 0;
    bit inrdy_pending = 0;
    logic [N:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] r;
        r = {1'b0, x} - {1'b0, y};
`ifdef SUB_ABS_EN
        if (x < y) r = {1'b1, y - x};
`endif
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (inrdy_pending) begin
            chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
            inrdy_pending = 0;
        end
        if (bus.in_valid && bus.in_ready) begin
            acc_edge = cyc + 1;
            if (b2b_mode && prev_acc >= 0) chk("accept_interval", 32'(acc_edge - prev_acc), 32'(LAT + 2));
            prev_acc = acc_edge;
        end
        if (bus.out_valid && !ov_prev) chk("latency", 32'(cyc - acc_edge), 32'(LAT));
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
            else chk("diff", 32'(bus.diff), 32'(sb.pop_front()));
            inrdy_pending = 1;
        end
        ov_prev = bus.out_valid;
    end

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N:0] e);
        bit acc;
        int g;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        acc = 0;
        g = 0;
        while (!acc && g < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            g++;
        end
        bus.in_valid = 1'b0;
        if (acc) sb.push_back(e);
        else chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((sb.size() != 0 || !bus.in_ready) && g < 300);
        chk("idle_timeout", 32'(g < 300), 32'd1);
    endtask

    initial begin
        bit acc;
        int cnt;
        int g;
        logic [N-1:0] x, y;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);

        send(10'd0, 10'd0, 11'd0);
        wait_idle();
        send(10'd100, 10'd47, 11'd53);
        wait_idle();
        send(10'd33, 10'd66, E_33_66);
        wait_idle();
        send(10'd1023, 10'd1023, 11'd0);
        wait_idle();
        send(10'd0, 10'd1023, E_0_1023);
        wait_idle();
        send(10'd1023, 10'd0, 11'd1023);
        wait_idle();

        // Backpressure: result must stay put and new operands must be ignored.
        bus.out_ready = 1'b0;
        send(10'd5, 10'd3, 11'd2);
        g = 0;
        while (!bus.out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("bp_ov_timeout", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            bus.in_valid = (i % 2 == 0);
            bus.a = 10'd1;
            bus.b = 10'd2;
            @(negedge clk);
            chk("bp_diff_hold", 32'(bus.diff), 32'd2);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();

        // Asynchronous reset partway through the shift phase.
        send(10'd900, 10'd100, 11'd800);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_diff", 32'(bus.diff), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(10'd7, 10'd9, E_7_9);
        wait_idle();

        // Back-to-back random jobs with in_valid and out_ready held high.
        b2b_mode = 1;
        prev_acc = -1;
        @(posedge clk); #1;
        x = N'($urandom_range(0, (1 << N) - 1));
        y = N'($urandom_range(0, (1 << N) - 1));
        bus.a = x;
        bus.b = y;
        bus.in_valid = 1'b1;
        cnt = 0;
        g = 0;
        while (cnt < 100 && g < 5000) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            g++;
            if (acc) begin
                sb.push_back(model(x, y));
                cnt++;
                x = N'($urandom_range(0, (1 << N) - 1));
                y = N'($urandom_range(0, (1 << N) - 1));
                bus.a = x;
                bus.b = y;
            end
        end
        bus.in_valid = 1'b0;
        chk("b2b_count", 32'(cnt), 32'd100);
        wait_idle();
        b2b_mode = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
